// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the PE-array output drain.
//   DW_DEFAULT    : default accumulator result width
//   idx_w()       : index width helper, $clog2 with a minimum of 1 bit
//   drain_state_t : drain FSM states
package pe_pkg;

    localparam int DW_DEFAULT = 32;

    // A one-entry dimension still needs a 1-bit index signal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/pe_arr_drain_if.sv
// pe_arr_drain_if: valid/ready element stream leaving the PE-array drain.
//   out_data  : current element
//   out_row   : row index of out_data
//   out_col   : column index of out_data
//   out_valid : element available
//   out_last  : element (ROWS-1, COLS-1)
//   out_ready : downstream accepts (driven by the consumer)
// Modports: master = drain side, slave = consumer side.
interface pe_arr_drain_if
    import pe_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = DW_DEFAULT
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    modport master (
        output out_data, out_row, out_col, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_row, out_col, out_valid, out_last,
        output out_ready
    );

endinterface

// File: rtl/drain_sat8.sv
// drain_sat8: combinational clamp of a signed DW-bit value to [-128, 127],
// sign-extended back to DW bits (requantisation to 8-bit activations).
//   din  : signed input value
//   dout : clamped, sign-extended value
module drain_sat8
    import pe_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    localparam logic signed [DW-1:0] SAT_MAX = DW'(127);
    localparam logic signed [DW-1:0] SAT_MIN = DW'(-128);

    always_comb begin
        dout = din;
        if ($signed(din) > SAT_MAX) begin
            dout = SAT_MAX;
        end else if ($signed(din) < SAT_MIN) begin
            dout = SAT_MIN;
        end
    end

endmodule

// File: rtl/pe_arr_drain.sv
// pe_arr_drain: snapshots the ROWS*COLS PE accumulator results once every
// in_valids bit is high (and arm is set), then streams them row-major, one
// element per beat, over the out_if valid/ready handshake.
//   clk       : clock, all logic on posedge
//   rstn      : synchronous active-low reset
//   arm       : permits capture of the next complete result set
//   in_outs   : PE results, index r*COLS+c
//   in_valids : per-PE valid
//   busy      : high from capture until the last beat is accepted
//   overrun   : sticky; an armed complete set arrived while draining
//   out_if    : element stream (master modport)
// Optional feature: define DRAIN_SAT8_EN to clamp out_data to [-128, 127].
module pe_arr_drain
    import pe_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic [DW-1:0]        in_outs [0:ROWS*COLS-1],
    input  logic [0:ROWS*COLS-1] in_valids,
    output logic                 busy,
    output logic                 overrun,
    pe_arr_drain_if.master       out_if
);
    localparam int N  = ROWS * COLS;
    localparam int IW = idx_w(N);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);

    drain_state_t  state_reg, state_next;
    logic [IW-1:0] index_reg, index_next;
    logic [RW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic [DW-1:0] data_reg, data_next;
    logic          overrun_reg;

    logic [DW-1:0] buf_mem [0:N-1];

    logic          all_valid;
    logic          capture;
    logic          last_beat;
    logic [IW-1:0] idx_inc;

    assign all_valid = &in_valids;
    assign capture   = (state_reg == IDLE) && arm && all_valid;
    assign last_beat = (state_reg == DRAIN) && (index_reg == LAST_IDX);
    assign idx_inc   = index_reg + 1'b1;

    // Snapshot buffer; untouched while draining because capture needs IDLE.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                buf_mem[k] <= in_outs[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            data_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            data_reg  <= data_next;
            if ((state_reg == DRAIN) && arm && all_valid) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // The element register is the registered read of the buffer: it is
    // preloaded from in_outs[0] at capture (buffer not yet written) and
    // from the next buffer slot on each accepted beat, so it holds while
    // out_ready is low.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    state_next = DRAIN;
                    index_next = '0;
                    row_next   = '0;
                    col_next   = '0;
                    data_next  = in_outs[0];
                end
            end
            DRAIN: begin
                if (out_if.out_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                        index_next = '0;
                        row_next   = '0;
                        col_next   = '0;
                        data_next  = '0;
                    end else begin
                        index_next = idx_inc;
                        data_next  = buf_mem[idx_inc];
                        if (col_reg == COL_MAX) begin
                            col_next = '0;
                            row_next = row_reg + 1'b1;
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy             = (state_reg == DRAIN);
    assign overrun          = overrun_reg;
    assign out_if.out_valid = (state_reg == DRAIN);
    assign out_if.out_last  = last_beat;
    assign out_if.out_row   = row_reg;
    assign out_if.out_col   = col_reg;

`ifdef DRAIN_SAT8_EN
    drain_sat8 #(.DW(DW)) u_sat8 (
        .din  (data_reg),
        .dout (out_if.out_data)
    );
`else
    assign out_if.out_data = data_reg;
`endif

endmodule

// File: tb/tb_pe_arr_drain.sv
// tb_pe_arr_drain: directed checks of pe_arr_drain (ROWS=COLS=8, DW=32):
// reset state, arming/valid gating, full drain, backpressure, overrun,
// reset mid-drain and the output clamp (when DRAIN_SAT8_EN is defined).
module tb_pe_arr_drain;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 32;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rstn;
    logic          arm;
    logic [DW-1:0] in_outs [0:N-1];
    logic [0:N-1]  in_valids;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    pe_arr_drain_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dif ();

    pe_arr_drain #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .in_outs   (in_outs),
        .in_valids (in_valids),
        .busy      (busy),
        .overrun   (overrun),
        .out_if    (dif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] v);
`ifdef DRAIN_SAT8_EN
        if ($signed(v) > 127)  return 32'sd127;
        if ($signed(v) < -128) return -32'sd128;
        return v;
`else
        return v;
`endif
    endfunction

    // Compares the presented element against beat number b of a drain.
    task automatic expect_beat(input int b, input logic [DW-1:0] exp);
        chk($sformatf("valid b%0d", b), {31'd0, dif.out_valid}, 32'd1);
        chk($sformatf("data b%0d", b), dif.out_data, exp);
        chk($sformatf("row b%0d", b), {29'd0, dif.out_row}, 32'(b / COLS));
        chk($sformatf("col b%0d", b), {29'd0, dif.out_col}, 32'(b % COLS));
        chk($sformatf("last b%0d", b), {31'd0, dif.out_last}, (b == N - 1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int beat;
        int cyc;

        rstn          = 1'b0;
        arm           = 1'b0;
        dif.out_ready = 1'b0;
        in_valids     = '0;
        for (int k = 0; k < N; k++) in_outs[k] = 32'(k + 1);

        // Reset state
        tick();
        tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst valid", {31'd0, dif.out_valid}, 32'd0);
        chk("rst overrun", {31'd0, overrun}, 32'd0);
        chk("rst last", {31'd0, dif.out_last}, 32'd0);
        chk("rst data", dif.out_data, 32'd0);
        chk("rst row", {29'd0, dif.out_row}, 32'd0);
        chk("rst col", {29'd0, dif.out_col}, 32'd0);

        // Gating: one PE not valid
        rstn          = 1'b1;
        dif.out_ready = 1'b1;
        in_valids     = '1;
        in_valids[37] = 1'b0;
        arm           = 1'b1;
        tick();
        tick();
        chk("gate37 busy", {31'd0, busy}, 32'd0);
        chk("gate37 valid", {31'd0, dif.out_valid}, 32'd0);
        chk("gate37 overrun", {31'd0, overrun}, 32'd0);

        // Gating: all valid, not armed
        in_valids[37] = 1'b1;
        arm           = 1'b0;
        tick();
        tick();
        chk("noarm busy", {31'd0, busy}, 32'd0);
        chk("noarm valid", {31'd0, dif.out_valid}, 32'd0);

        // Basic capture and full drain at out_ready=1
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("cap busy", {31'd0, busy}, 32'd1);
        for (int b = 0; b < N; b++) begin
            expect_beat(b, 32'(b + 1));
            tick();
        end
        chk("basic end busy", {31'd0, busy}, 32'd0);
        chk("basic end valid", {31'd0, dif.out_valid}, 32'd0);
        chk("basic overrun", {31'd0, overrun}, 32'd0);

        // Backpressure: out_ready low on even cycles, high on odd cycles
        arm = 1'b1;
        tick();
        arm  = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < N && cyc < 300) begin
            dif.out_ready = cyc[0];
            expect_beat(beat, 32'(beat + 1));
            tick();
            if (dif.out_ready) beat++;
            cyc++;
        end
        chk("bp cycles", 32'(cyc), 32'd128);
        chk("bp beats", 32'(beat), 32'(N));
        chk("bp end busy", {31'd0, busy}, 32'd0);
        dif.out_ready = 1'b1;

        // Overrun: armed second set mid-drain is dropped
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int b = 0; b < N; b++) begin
            expect_beat(b, 32'(b + 1));
            if (b == 10) begin
                for (int k = 0; k < N; k++) in_outs[k] = 32'(1000 + k);
                arm = 1'b1;
            end
            tick();
            arm = 1'b0;
            if (b == 10) chk("ovr set", {31'd0, overrun}, 32'd1);
        end
        chk("ovr end busy", {31'd0, busy}, 32'd0);
        chk("ovr sticky", {31'd0, overrun}, 32'd1);
        for (int k = 0; k < N; k++) in_outs[k] = 32'(k + 1);

        // Reset mid-drain at beat 20
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int b = 0; b < 20; b++) tick();
        expect_beat(20, 32'd21);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst valid", {31'd0, dif.out_valid}, 32'd0);
        chk("mrst busy", {31'd0, busy}, 32'd0);
        chk("mrst overrun", {31'd0, overrun}, 32'd0);
        chk("mrst data", dif.out_data, 32'd0);
        tick();
        chk("mrst idle valid", {31'd0, dif.out_valid}, 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        expect_beat(0, 32'd1);
        for (int b = 0; b < N; b++) tick();
        chk("mrst drain end", {31'd0, busy}, 32'd0);

        // Clamp vectors (pass-through unless DRAIN_SAT8_EN)
        in_outs[0] = 32'sd300;
        in_outs[1] = -32'sd300;
        in_outs[2] = 32'sd127;
        in_outs[3] = -32'sd128;
        in_outs[4] = 32'sd5;
        in_outs[5] = -32'sd129;
        in_outs[6] = 32'sd128;
        in_outs[7] = -32'sd1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int b = 0; b < 8; b++) begin
            expect_beat(b, exp_out(in_outs[b]));
            tick();
        end
        for (int b = 8; b < N; b++) tick();
        chk("sat end busy", {31'd0, busy}, 32'd0);
        chk("final overrun", {31'd0, overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_arr_drain.md
Name: pe_arr_drain

Overview:
- Reader at the output side of PE_ARR.
- Snapshots the ROWS*COLS accumulator results once every PE's outvalid is high.
- Streams the snapshot out one element per beat, row-major, over a valid/ready handshake.
- Drives a busy flag so the controller holds fire low while the drain is in progress.

Parameters:
- ROWS, 8, PE array rows.
- COLS, 8, PE array columns.
- DW, 32, result width; matches PE_ARR outs.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- arm  in  1  permits capture of the next complete result set.
- in_outs  in  DW x [0:ROWS*COLS-1]  PE results; index r*COLS+c.
- in_valids  in  1 x [0:ROWS*COLS-1]  per-PE valid.
- out_data  out  DW  current element.
- out_row  out  $clog2(ROWS) (min 1)  row index of out_data.
- out_col  out  $clog2(COLS) (min 1)  column index of out_data.
- out_valid  out  1  element available.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks element (ROWS-1, COLS-1).
- busy  out  1  high from capture until the last beat is accepted.
- overrun  out  1  sticky; a complete set arrived while busy.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE; index=0.
  - out_valid, out_last, busy, overrun all 0.
  - out_data, out_row, out_col all 0.
  - Buffer contents are don't-care.
  - Reset mid-drain discards the drain; no further beats are issued.
- all_valid = AND of in_valids[0..ROWS*COLS-1].
- IDLE:
  - If arm && all_valid at a posedge: copy all in_outs into the buffer, set index=0, go to DRAIN.
  - busy and out_valid rise the following cycle, so the first element appears 1 cycle after the capture edge.
  - all_valid without arm: ignored, no overrun.
- DRAIN:
  - out_valid=1.
  - out_data = buf[index]; out_row = index/COLS; out_col = index%COLS.
  - out_last = (index == ROWS*COLS-1).
  - On out_valid && out_ready: increment index.
    - If out_last: go to IDLE; busy and out_valid drop next cycle.
  - While out_ready=0: out_data, out_row, out_col and out_last hold stable.
  - Buffer is not rewritten while in DRAIN.
- Overrun:
  - Set when all_valid && arm in DRAIN, including the last-beat cycle.
  - Those results are dropped.
  - Cleared only by reset.
- Back-to-back sets:
  - Capture from IDLE only; minimum gap is one IDLE cycle after the last handshake.
  - Sustained throughput is ROWS*COLS+1 cycles per set with out_ready=1.
- Degenerate case ROWS=COLS=1: out_last is high on the first beat; out_row and out_col are 0.
- Data is passed bit-exact (two's complement) unless the optional feature is enabled.

Optional Feature:
- Macro: DRAIN_SAT8_EN.
- Defined: out_data is the signed buffer value clamped to [-128, 127] and sign-extended to DW (requantisation for the next layer's 8-bit activations). Clamping is combinational on the output, so latency is unchanged.
- Undefined: out_data = buffer value, unmodified.

Decomposition:
- Shared package pe_pkg:
  - DW default.
  - Index-width helper function (clog2 with minimum 1).
  - drain_state_t enum {IDLE, DRAIN}.
- Sub-module drain_sat8: a single combinational clamp. It is instantiated only under DRAIN_SAT8_EN and is otherwise bypassed.
- Buffer and FSM stay in pe_arr_drain.

Test Plan:
- Basic capture (ROWS=COLS=8):
  - Stimulus: in_outs[k]=k+1, all valids=1, arm=1, out_ready=1.
  - Response: 64 beats on consecutive cycles starting 1 cycle after capture; data 1..64; (row, col) counts (0,0)..(7,7); out_last only on beat 64; busy low the cycle after.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 every cycle.
  - Response: each element held while stalled; 64 beats in 128 cycles; no value repeated or skipped.
- Gating:
  - Stimulus: valids all 1 except index 37, arm=1.
  - Response: no capture; busy=0; out_valid=0.
  - Then set valid[37]=1: capture occurs.
  - With all valid but arm=0: no capture.
- Overrun and stability:
  - Stimulus: second complete set (values 1000+k) presented mid-drain.
  - Response: overrun=1 sticky; drained data remains 1..64.
- Reset mid-drain:
  - Stimulus: rstn=0 for one cycle at beat 20.
  - Response: next cycle out_valid=0, busy=0, overrun=0; a fresh capture then restarts at (0,0).
- DRAIN_SAT8_EN:
  - Stimulus: in_outs = {300, -300, 127, -128, 5, ...}.
  - Response: out_data = {127, -128, 127, -128, 5, ...} sign-extended.
  - Without the macro: {300, -300, ...} unchanged.
